aes_dec_block_loader: RTL and testbench
=======================================

Name: aes_dec_block_loader

Overview:
- Byte-serial input stage directly upstream of the AES-128 decryption core.
- Assembles a 128-bit cipher key and a 128-bit ciphertext block from an 8-bit valid/ready stream.
- Presents both words to the core over a single valid/ready handshake.
- Supports key reuse across consecutive blocks, so a block can be loaded without re-sending the key.

Parameters:
- BYTES, 16, bytes per key and per ciphertext block. Fixed at 16 for AES-128; other values are unsupported.
- CNT_W, 4, width of the byte counter. Must equal log2(BYTES).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort; returns the block to the post-reset state.
- byte_in  input  8  serial data byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts byte_in this cycle.
- reuse_key  input  1  sampled on the core handshake; 1 means the next block skips key loading.
- core_key  output  128  assembled key; the first byte received is at [127:120].
- core_ct  output  128  assembled ciphertext; the first byte received is at [127:120].
- core_valid  output  1  core_key and core_ct are complete and stable.
- core_ready  input  1  the core accepts the block.
- loading_key  output  1  1 while in LOAD_KEY.
- byte_cnt  output  CNT_W  bytes accepted in the current phase (0..15).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=LOAD_KEY, byte_cnt=0, core_key=0, core_ct=0, core_valid=0, loading_key=1.
  - byte_ready decodes from state, so it reads 1 immediately after reset.
- Accept = byte_valid & byte_ready. Nothing changes when byte_valid=1 and byte_ready=0.
- States:
  - LOAD_KEY: byte_ready=1. On accept, core_key <= {core_key[119:0], byte_in} and byte_cnt increments. On the 16th accept (byte_cnt==15), byte_cnt wraps to 0 and next state is LOAD_CT.
  - LOAD_CT: byte_ready=1. On accept, core_ct <= {core_ct[119:0], byte_in}; core_key is untouched. On the 16th accept, byte_cnt wraps to 0, next state is PRESENT, and core_valid is set.
  - PRESENT: byte_ready=0, core_valid=1. core_key and core_ct are held stable until the handshake.
    - On core_valid & core_ready: core_valid clears the next cycle.
    - Next state is LOAD_CT if reuse_key=1 in the handshake cycle, else LOAD_KEY.
    - core_key keeps its value either way; core_ct keeps its value until it is overwritten by shifting.
- Latency and throughput:
  - Last ciphertext byte accepted in cycle N -> core_valid=1 in cycle N+1.
  - With core_ready held at 1, the handshake completes in cycle N+1 and byte_ready returns to 1 in cycle N+2.
  - No bypass. Minimum 33 cycles per block with a key, 17 with reuse_key=1.
- clear=1:
  - Overrides everything else in that cycle, including an accept or a core handshake.
  - Next cycle: state=LOAD_KEY, byte_cnt=0, core_valid=0, core_key=0, core_ct=0.
  - Mid-block bytes are discarded. clear is legal in any state.
- reuse_key is ignored outside the PRESENT handshake cycle.
  - After reset or clear, a key is always loaded first, regardless of reuse_key.
- Mid-operation rst_n assertion is treated the same as clear, but asynchronously.
  - Outputs go to their reset values immediately, without waiting for a clock edge.
- byte_cnt resets to 0 at each phase change. It never exceeds 15.

Test Plan:
- FIPS-197 C.1 vector, streamed with byte_valid held at 1:
  - Stimulus: key bytes 00,01,..,0f, then ciphertext 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a.
  - Required: core_key=000102030405060708090a0b0c0d0e0f and core_ct=69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: core_valid=1 exactly one cycle after the 32nd accept, and byte_ready=0 while core_valid=1.
- Backpressure: hold core_ready=0 for 10 cycles while byte_valid=1 with random data.
  - Required: core_key, core_ct and core_valid are stable for all 10 cycles; no byte is accepted.
  - Then pulse core_ready=1: core_valid=0 the next cycle, and byte_ready returns to 1 in that same next cycle.
- Key reuse: after the first block, complete the handshake with reuse_key=1, then send 16 bytes of ff.
  - Required: core_key is still 000102..0f and core_ct=ff..ff.
  - Required: core_valid rises after 16 accepts; loading_key stays 0 throughout.
- Valid gaps: toggle byte_valid pseudo-randomly (~50% duty) across the same C.1 vector.
  - Required: identical core_key and core_ct to the first scenario; byte_cnt advances only on accept cycles.
- Abort: assert clear after 7 ciphertext bytes.
  - Required: next cycle state=LOAD_KEY, byte_cnt=0, core_key=0, core_ct=0.
  - Required: a full key+ciphertext reload produces the correct block.
  - Also assert clear in the same cycle as a PRESENT handshake with reuse_key=1 -> the block returns to LOAD_KEY, not LOAD_CT.
- Async reset: drop rst_n mid-LOAD_CT, between clock edges.
  - Required: core_valid=0, byte_cnt=0 and loading_key=1 before the next rising edge.
  - Required: after release, the first accepted byte lands in core_key.

Source files
------------

// File: rtl/aes_dec_block_loader.sv
// aes_dec_block_loader: byte-serial loader packing a 128-bit key and ciphertext for the AES-128 decrypt core (byte stream in, valid/ready block out, optional key reuse)
module aes_dec_block_loader #(
  parameter int BYTES = 16,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  input  logic               reuse_key,
  output logic [8*BYTES-1:0] core_key,
  output logic [8*BYTES-1:0] core_ct,
  output logic               core_valid,
  input  logic               core_ready,
  output logic               loading_key,
  output logic [CNT_W-1:0]   byte_cnt
);
  typedef enum logic [1:0] {LOAD_KEY, LOAD_CT, PRESENT} state_t;
  state_t state, state_nxt;
  logic accept, last;
  assign byte_ready  = state != PRESENT;
  assign core_valid  = state == PRESENT;
  assign loading_key = state == LOAD_KEY;
  assign accept      = byte_valid & byte_ready;
  assign last        = byte_cnt == CNT_W'(BYTES - 1);
  always_comb begin
    state_nxt = clear ? LOAD_KEY :
                (accept && last) ? (state == LOAD_KEY ? LOAD_CT : PRESENT) :
                (core_valid && core_ready) ? (reuse_key ? LOAD_CT : LOAD_KEY) :
                state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD_KEY;
      byte_cnt <= '0;
      core_key <= '0;
      core_ct  <= '0;
    end else if (clear) begin
      state    <= LOAD_KEY;
      byte_cnt <= '0;
      core_key <= '0;
      core_ct  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) byte_cnt <= last ? '0 : byte_cnt + 1'b1;
      if (accept && state == LOAD_KEY) core_key <= {core_key[8*BYTES-9:0], byte_in};
      if (accept && state == LOAD_CT) core_ct <= {core_ct[8*BYTES-9:0], byte_in};
    end
  end
endmodule

// File: tb/tb_aes_dec_block_loader.sv
// tb_aes_dec_block_loader: directed self-checking bench for aes_dec_block_loader
module tb_aes_dec_block_loader;
  logic clk = 0, rst_n = 0, clear = 0, byte_valid = 0, reuse_key = 0, core_ready = 0;
  logic [7:0] byte_in = 0;
  logic byte_ready, core_valid, loading_key;
  logic [127:0] core_key, core_ct;
  logic [3:0] byte_cnt;
  aes_dec_block_loader dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .reuse_key(reuse_key), .core_key(core_key), .core_ct(core_ct),
    .core_valid(core_valid), .core_ready(core_ready), .loading_key(loading_key), .byte_cnt(byte_cnt)
  );
  always #5 clk = ~clk;
  int vecs = 0, errs = 0;
  logic [127:0] k_v = 128'h000102030405060708090a0b0c0d0e0f;
  logic [127:0] ct_v = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic [127:0] ones = {128{1'b1}};
  logic [7:0] c1 [32];
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    byte_valid = 1;
    byte_in = b;
    step();
    byte_valid = 0;
  endtask
  task automatic handshake(input logic reuse);
    core_ready = 1;
    reuse_key = reuse;
    step();
    core_ready = 0;
    reuse_key = 0;
  endtask
  initial begin
    int idx;
    logic v;
    for (int i = 0; i < 16; i++) begin
      c1[i] = 8'(i);
      c1[16+i] = ct_v[127-8*i -: 8];
    end
    step();
    check("rst_valid", 128'(core_valid), 128'(0));
    check("rst_ready", 128'(byte_ready), 128'(1));
    check("rst_lk", 128'(loading_key), 128'(1));
    check("rst_cnt", 128'(byte_cnt), 128'(0));
    check("rst_key", core_key, 128'(0));
    check("rst_ct", core_ct, 128'(0));
    rst_n = 1;
    step();
    byte_valid = 1;
    for (int i = 0; i < 32; i++) begin
      byte_in = c1[i];
      check("c1_ready", 128'(byte_ready), 128'(1));
      step();
      if (i == 15) check("c1_lk", 128'(loading_key), 128'(0));
      if (i == 15) check("c1_cnt_wrap", 128'(byte_cnt), 128'(0));
      if (i == 30) check("c1_early_valid", 128'(core_valid), 128'(0));
    end
    check("c1_valid", 128'(core_valid), 128'(1));
    check("c1_ready_lo", 128'(byte_ready), 128'(0));
    check("c1_key", core_key, k_v);
    check("c1_ct", core_ct, ct_v);
    for (int i = 0; i < 10; i++) begin
      byte_in = 8'($urandom);
      step();
      check("bp_key", core_key, k_v);
      check("bp_ct", core_ct, ct_v);
      check("bp_valid", 128'(core_valid), 128'(1));
      check("bp_cnt", 128'(byte_cnt), 128'(0));
    end
    byte_valid = 0;
    handshake(1);
    check("hs_valid", 128'(core_valid), 128'(0));
    check("hs_ready", 128'(byte_ready), 128'(1));
    check("hs_lk", 128'(loading_key), 128'(0));
    for (int i = 0; i < 16; i++) begin
      send(8'hff);
      check("reuse_lk", 128'(loading_key), 128'(0));
      if (i == 14) check("reuse_early_valid", 128'(core_valid), 128'(0));
    end
    check("reuse_valid", 128'(core_valid), 128'(1));
    check("reuse_key", core_key, k_v);
    check("reuse_ct", core_ct, ones);
    handshake(0);
    check("noreuse_lk", 128'(loading_key), 128'(1));
    idx = 0;
    for (int c = 0; c < 600 && idx < 32; c++) begin
      v = 1'($urandom_range(0, 1));
      byte_valid = v;
      byte_in = v ? c1[idx] : 8'($urandom);
      step();
      if (v) idx++;
      check("gap_cnt", 128'(byte_cnt), 128'(idx % 16));
    end
    byte_valid = 0;
    check("gap_done", 128'(idx), 128'(32));
    check("gap_valid", 128'(core_valid), 128'(1));
    check("gap_key", core_key, k_v);
    check("gap_ct", core_ct, ct_v);
    handshake(0);
    for (int i = 0; i < 23; i++) send(c1[i]);
    check("ab_cnt_pre", 128'(byte_cnt), 128'(7));
    clear = 1;
    step();
    clear = 0;
    check("ab_lk", 128'(loading_key), 128'(1));
    check("ab_cnt", 128'(byte_cnt), 128'(0));
    check("ab_key", core_key, 128'(0));
    check("ab_ct", core_ct, 128'(0));
    for (int i = 0; i < 32; i++) send(c1[i]);
    check("ab_re_valid", 128'(core_valid), 128'(1));
    check("ab_re_key", core_key, k_v);
    check("ab_re_ct", core_ct, ct_v);
    clear = 1;
    handshake(1);
    clear = 0;
    check("abhs_lk", 128'(loading_key), 128'(1));
    check("abhs_valid", 128'(core_valid), 128'(0));
    check("abhs_key", core_key, 128'(0));
    send(8'h5a);
    check("abhs_key1", core_key, 128'h5a);
    check("abhs_ct1", core_ct, 128'(0));
    clear = 1;
    step();
    clear = 0;
    for (int i = 0; i < 19; i++) send(c1[i]);
    check("ar_cnt_pre", 128'(byte_cnt), 128'(3));
    check("ar_lk_pre", 128'(loading_key), 128'(0));
    #2 rst_n = 0;
    #1;
    check("ar_valid", 128'(core_valid), 128'(0));
    check("ar_cnt", 128'(byte_cnt), 128'(0));
    check("ar_lk", 128'(loading_key), 128'(1));
    step();
    rst_n = 1;
    step();
    send(8'hab);
    check("ar_key", core_key, 128'hab);
    check("ar_ct", core_ct, 128'(0));
    check("ar_cnt1", 128'(byte_cnt), 128'(1));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
